// File: rtl/stage_phase_modulator_pkg.sv
// Shared synth types and helpers for the phase-modulation stage.
// Slot IDs are {voice, operator}; table rows are voice*NUM_OPERATORS+operator.
package stage_phase_modulator_pkg;

  localparam int DEF_NUM_VOICES      = 32;
  localparam int DEF_NUM_OPERATORS   = 6;
  localparam int VOICE_W             = $clog2(DEF_NUM_VOICES);
  localparam int OP_W                = $clog2(DEF_NUM_OPERATORS);
  localparam int FEEDBACK_W          = 3;
  localparam int FEEDBACK_BASE_SHIFT = 9;

  typedef struct packed {
    logic [VOICE_W-1:0] voice;
    logic [OP_W-1:0]    op;
  } VoiceOperatorID_t;

  typedef struct packed {
    logic [FEEDBACK_W-1:0]        FeedbackLevel;
    logic                         IsCarrier;
    logic [DEF_NUM_OPERATORS-1:0] ModulateWithOP;
  } AlgorithmWord_t;

  function automatic int unsigned getVoiceID(
    input int unsigned id,
    input int unsigned op_w
  );
    return id >> op_w;
  endfunction

  function automatic int unsigned getOperatorID(
    input int unsigned id,
    input int unsigned op_w
  );
    return id & ((32'd1 << op_w) - 32'd1);
  endfunction

endpackage

// File: rtl/modulator_output_ram.sv
// One-write one-read table with registered read and write-first bypass.
// A write and read of the same row in one cycle returns the new data.
module modulator_output_ram #(
  parameter  int DEPTH = 192,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = mem_q[raddr_i];
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stage_phase_modulator.sv
// FM phase-modulation stage: adds selected operator outputs to the raw phase.
// Define OCTANE_MODULATOR_FEEDBACK_EN to build the operator self-feedback path.
module stage_phase_modulator
  import stage_phase_modulator_pkg::*;
#(
  parameter  int NUM_VOICES    = 32,
  parameter  int NUM_OPERATORS = 6,
  parameter  int PHASE_WIDTH   = 16,
  parameter  int OUTPUT_WIDTH  = 16,
  parameter  int MOD_SHIFT     = 1,
  localparam int ID_W = $clog2(NUM_VOICES) + $clog2(NUM_OPERATORS),
  localparam int AW_W = NUM_OPERATORS + 4
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Valid,
  input  logic [PHASE_WIDTH-1:0]  i_Phase,
  input  logic                    i_NoteOn,
  input  logic [ID_W-1:0]         i_VoiceOperator,
  input  logic                    i_WritebackEnable,
  input  logic [ID_W-1:0]         i_WritebackID,
  input  logic [OUTPUT_WIDTH-1:0] i_WritebackValue,
  input  logic                    i_AlgorithmWriteEnable,
  input  logic [ID_W-1:0]         i_ConfigWriteAddr,
  input  logic [15:0]             i_ConfigWriteData,
  output logic                    o_Ready,
  output logic                    o_Valid,
  output logic                    o_NoteOn,
  output logic [PHASE_WIDTH-1:0]  o_Phase,
  output logic [ID_W-1:0]         o_VoiceOperator,
  output logic [AW_W-1:0]         o_AlgorithmWord
);

  localparam int OPB   = $clog2(NUM_OPERATORS);
  localparam int DEPTH = NUM_VOICES * NUM_OPERATORS;
  localparam int AW    = $clog2(DEPTH);
  localparam int NST   = NUM_OPERATORS + 1;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [FEEDBACK_W-1:0]    FeedbackLevel;
    logic                     IsCarrier;
    logic [NUM_OPERATORS-1:0] ModulateWithOP;
  } alg_t;

  typedef struct packed {
    logic                   valid;
    logic                   note_on;
    logic [ID_W-1:0]        id;
    logic [PHASE_WIDTH-1:0] phase;
    alg_t                   alg;
  } slot_t;

  function automatic logic [AW-1:0] slotAddr(
    input logic [ID_W-1:0] id,
    input int unsigned     op
  );
    return AW'(getVoiceID(32'(id), OPB) * NUM_OPERATORS + op);
  endfunction

  function automatic logic [AW-1:0] addrOf(
    input logic [ID_W-1:0] id
  );
    return slotAddr(id, getOperatorID(32'(id), OPB));
  endfunction

  function automatic logic [PHASE_WIDTH-1:0] scaleMod(
    input logic [OUTPUT_WIDTH-1:0] v
  );
    logic signed [OUTPUT_WIDTH-1:0] s;
    s = $signed(v) >>> MOD_SHIFT;
    return PHASE_WIDTH'(s);
  endfunction

  // Clear sequencer
  state_e        state_q;
  logic [AW-1:0] clr_cnt_q;
  logic          ready_q;
  logic          clearing;
  logic          running;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + AW'(1);
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_CLEAR;
        end
      endcase
    end
  end

  assign clearing = (state_q == ST_CLEAR);
  assign running  = ~clearing;

  // Algorithm table
  logic [AW_W-1:0] alg_mem_q [DEPTH];
  logic            alg_we;
  logic [AW-1:0]   alg_waddr;
  logic [AW_W-1:0] alg_wdata;
  logic [AW-1:0]   alg_raddr;
  logic [AW_W-1:0] alg_rd;
  logic            unused_cfg;

  assign alg_we    = clearing | i_AlgorithmWriteEnable;
  assign alg_waddr = clearing ? clr_cnt_q : addrOf(i_ConfigWriteAddr);
  assign alg_wdata = clearing ? '0 : i_ConfigWriteData[AW_W-1:0];
  assign alg_raddr = addrOf(i_VoiceOperator);
  assign alg_rd    = (alg_we && (alg_waddr == alg_raddr))
                   ? alg_wdata : alg_mem_q[alg_raddr];
  assign unused_cfg = ^i_ConfigWriteData[15:AW_W];

  always_ff @(posedge i_Clock) begin
    if (alg_we) begin
      alg_mem_q[alg_waddr] <= alg_wdata;
    end
  end

  // Operator output table, one read-port replica per tap
  logic                    tbl_we;
  logic [AW-1:0]           tbl_waddr;
  logic [OUTPUT_WIDTH-1:0] tbl_wdata;
  logic [OUTPUT_WIDTH-1:0] op_rd    [NUM_OPERATORS];
  logic [PHASE_WIDTH-1:0]  mod_term [NUM_OPERATORS];
  logic [PHASE_WIDTH-1:0]  fb_term;
  slot_t                   s_q [NST];
  slot_t                   s_d [NST];

  assign tbl_we    = clearing | i_WritebackEnable;
  assign tbl_waddr = clearing ? clr_cnt_q : addrOf(i_WritebackID);
  assign tbl_wdata = clearing ? '0 : i_WritebackValue;

  for (genvar k = 0; k < NUM_OPERATORS; k++) begin : g_rep
    logic [AW-1:0] raddr;
    if (k == 0) begin : g_first
      assign raddr = slotAddr(i_VoiceOperator, 32'd0);
    end else begin : g_rest
      assign raddr = slotAddr(s_q[k-1].id, 32'(k));
    end

    modulator_output_ram #(
      .DEPTH (DEPTH),
      .WIDTH (OUTPUT_WIDTH)
    ) u_ram (
      .clk_i   (i_Clock),
      .we_i    (tbl_we),
      .waddr_i (tbl_waddr),
      .wdata_i (tbl_wdata),
      .raddr_i (raddr),
      .rdata_o (op_rd[k])
    );

    assign mod_term[k] = s_q[k].alg.ModulateWithOP[k]
                       ? scaleMod(op_rd[k]) : '0;
  end

`ifdef OCTANE_MODULATOR_FEEDBACK_EN
  // Writebacks alternate between two tables; h1+h2 is order independent.
  logic [DEPTH-1:0]               tog_q;
  logic                           wb_hit;
  logic [AW-1:0]                  wb_addr;
  logic                           hist_a_we;
  logic                           hist_b_we;
  logic [OUTPUT_WIDTH-1:0]        hist_a;
  logic [OUTPUT_WIDTH-1:0]        hist_b;
  logic signed [OUTPUT_WIDTH:0]   fb_sum;
  logic signed [OUTPUT_WIDTH:0]   fb_shr;
  logic [3:0]                     fb_sh;

  assign wb_hit    = running & i_WritebackEnable;
  assign wb_addr   = addrOf(i_WritebackID);
  assign hist_a_we = clearing | (wb_hit & ~tog_q[wb_addr]);
  assign hist_b_we = clearing | (wb_hit & tog_q[wb_addr]);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tog_q <= '0;
    end else if (clearing) begin
      tog_q[clr_cnt_q] <= 1'b0;
    end else if (wb_hit) begin
      tog_q[wb_addr] <= ~tog_q[wb_addr];
    end
  end

  modulator_output_ram #(
    .DEPTH (DEPTH),
    .WIDTH (OUTPUT_WIDTH)
  ) u_hist_a (
    .clk_i   (i_Clock),
    .we_i    (hist_a_we),
    .waddr_i (tbl_waddr),
    .wdata_i (tbl_wdata),
    .raddr_i (alg_raddr),
    .rdata_o (hist_a)
  );

  modulator_output_ram #(
    .DEPTH (DEPTH),
    .WIDTH (OUTPUT_WIDTH)
  ) u_hist_b (
    .clk_i   (i_Clock),
    .we_i    (hist_b_we),
    .waddr_i (tbl_waddr),
    .wdata_i (tbl_wdata),
    .raddr_i (alg_raddr),
    .rdata_o (hist_b)
  );

  always_comb begin
    fb_sum  = $signed({hist_a[OUTPUT_WIDTH-1], hist_a})
            + $signed({hist_b[OUTPUT_WIDTH-1], hist_b});
    fb_sh   = 4'(FEEDBACK_BASE_SHIFT) - {1'b0, s_q[0].alg.FeedbackLevel};
    fb_shr  = fb_sum >>> fb_sh;
    fb_term = '0;
    if (s_q[0].alg.FeedbackLevel != '0) begin
      fb_term = PHASE_WIDTH'(fb_shr);
    end
  end
`else
  assign fb_term = '0;
`endif

  // Modulation pipeline
  always_comb begin
    s_d[0].valid   = i_Valid & running;
    s_d[0].note_on = i_NoteOn;
    s_d[0].id      = i_VoiceOperator;
    s_d[0].phase   = i_Phase;
    s_d[0].alg     = alg_t'(alg_rd);
    for (int k = 1; k < NST; k++) begin
      s_d[k]       = s_q[k-1];
      s_d[k].phase = s_q[k-1].phase + mod_term[k-1]
                   + ((k == 1) ? fb_term : '0);
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      for (int k = 0; k < NST; k++) begin
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NST; k++) begin
        s_q[k] <= s_d[k];
      end
    end
  end

  assign o_Ready         = ready_q;
  assign o_Valid         = s_q[NST-1].valid;
  assign o_NoteOn        = s_q[NST-1].note_on;
  assign o_Phase         = s_q[NST-1].phase;
  assign o_VoiceOperator = s_q[NST-1].id;
  assign o_AlgorithmWord = s_q[NST-1].alg;

endmodule

// File: tb/tb_stage_phase_modulator.sv
// Directed bench for stage_phase_modulator: vector table plus corner sequences.
// Feedback expectations follow OCTANE_MODULATOR_FEEDBACK_EN.
`timescale 1ns/1ps
module tb_stage_phase_modulator;

  localparam int IDW = 8;
  localparam int AWW = 10;
  localparam int LAT = 7;
  localparam int CLR = 192;

  logic            clk = 1'b0;
  logic            rst;
  logic            vin;
  logic [15:0]     ph_in;
  logic            non;
  logic [IDW-1:0]  vo;
  logic            wb_en;
  logic [IDW-1:0]  wb_id;
  logic [15:0]     wb_val;
  logic            aw_en;
  logic [IDW-1:0]  cfg_addr;
  logic [15:0]     cfg_data;
  logic            rdy;
  logic            vout;
  logic            nout;
  logic [15:0]     ph_out;
  logic [IDW-1:0]  vo_out;
  logic [AWW-1:0]  alg_out;

  always #5 clk = ~clk;

  stage_phase_modulator dut (
    .i_Clock                (clk),
    .i_Reset                (rst),
    .i_Valid                (vin),
    .i_Phase                (ph_in),
    .i_NoteOn               (non),
    .i_VoiceOperator        (vo),
    .i_WritebackEnable      (wb_en),
    .i_WritebackID          (wb_id),
    .i_WritebackValue       (wb_val),
    .i_AlgorithmWriteEnable (aw_en),
    .i_ConfigWriteAddr      (cfg_addr),
    .i_ConfigWriteData      (cfg_data),
    .o_Ready                (rdy),
    .o_Valid                (vout),
    .o_NoteOn               (nout),
    .o_Phase                (ph_out),
    .o_VoiceOperator        (vo_out),
    .o_AlgorithmWord        (alg_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IDW-1:0] sid(input int v, input int o);
    return IDW'(v * 8 + o);
  endfunction

  task automatic wb(input logic [IDW-1:0] id, input logic [15:0] val);
    wb_en = 1'b1; wb_id = id; wb_val = val;
    @(negedge clk);
    wb_en = 1'b0;
  endtask

  task automatic algw(input logic [IDW-1:0] id, input logic [15:0] d);
    aw_en = 1'b1; cfg_addr = id; cfg_data = d;
    @(negedge clk);
    aw_en = 1'b0;
  endtask

  task automatic wait_ready(output int cyc, output logic saw_v);
    cyc = 0; saw_v = 1'b0;
    while (!rdy && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (vout) saw_v = 1'b1;
    end
  endtask

  // Issue one slot, optionally with same-cycle writeback / algorithm write.
  task automatic run_slot(
    input  logic [IDW-1:0] id,   input  logic [15:0] ph,
    input  logic           w_en, input  logic [IDW-1:0] w_id,
    input  logic [15:0]    w_v,  input  logic        a_en,
    input  logic [15:0]    a_d,
    output logic [15:0]    g_ph, output logic [AWW-1:0] g_alg,
    output logic [IDW-1:0] g_id, output logic        g_note,
    output int             lat);
    vin = 1'b1; vo = id; ph_in = ph; non = 1'b1;
    wb_en = w_en; wb_id = w_id; wb_val = w_v;
    aw_en = a_en; cfg_addr = id; cfg_data = a_d;
    @(negedge clk);
    vin = 1'b0; non = 1'b0; wb_en = 1'b0; aw_en = 1'b0;
    lat = 1;
    while (!vout && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    g_ph = ph_out; g_alg = alg_out; g_id = vo_out; g_note = nout;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] alg;
    logic [15:0] w [6];
    logic [15:0] ph;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [11];

  logic [15:0]    g_ph;
  logic [AWW-1:0] g_alg;
  logic [IDW-1:0] g_id;
  logic           g_note;
  int             lat;
  int             cyc;
  logic           saw_v;
  logic [15:0]    exp_fb;

  initial begin
    vt[0]  = '{16'h000, '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h1234, 16'h1234};
    vt[1]  = '{16'h001, '{16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h1234, 16'h2234};
    vt[2]  = '{16'h003, '{16'h7FFE, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hC000, 16'hBFFF};
    vt[3]  = '{16'h001, '{16'h7FFE, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hC000, 16'hFFFF};
    vt[4]  = '{16'h003, '{16'h7FFE, 16'h7FFE, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hC000, 16'h3FFE};
    vt[5]  = '{16'h002, '{16'h7FFE, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 16'hFFFF};
    vt[6]  = '{16'h040, '{16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h1000, 16'h1000};
    vt[7]  = '{16'h03F, '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040}, 16'h0100, 16'h013F};
    vt[8]  = '{16'h020, '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE}, 16'h0000, 16'hFFFF};
    vt[9]  = '{16'h001, '{16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'hFFFF, 16'h0000};
    vt[10] = '{16'h030, '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0800}, 16'h0000, 16'h0C00};

    rst = 1'b1; vin = 1'b0; ph_in = '0; non = 1'b0; vo = '0;
    wb_en = 1'b0; wb_id = '0; wb_val = '0;
    aw_en = 1'b0; cfg_addr = '0; cfg_data = '0;

    #1;
    check("rst_ready",  32'(rdy),     32'h0);
    check("rst_valid",  32'(vout),    32'h0);
    check("rst_noteon", 32'(nout),    32'h0);
    check("rst_phase",  32'(ph_out),  32'h0);
    check("rst_id",     32'(vo_out),  32'h0);
    check("rst_alg",    32'(alg_out), 32'h0);

    // Traffic and table writes during CLEAR must be ignored.
    repeat (3) @(negedge clk);
    vin = 1'b1; vo = sid(3, 5); ph_in = 16'h4321;
    aw_en = 1'b1; cfg_addr = sid(3, 5); cfg_data = 16'h03F;
    wb_en = 1'b1; wb_id = sid(3, 0); wb_val = 16'h7FFE;
    rst = 1'b0;
    wait_ready(cyc, saw_v);
    vin = 1'b0; aw_en = 1'b0; wb_en = 1'b0;
    check("clear_cycles", 32'(cyc), 32'(CLR));
    check("clear_no_valid", 32'(saw_v), 32'h0);
    saw_v = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (vout) saw_v = 1'b1;
    end
    check("clear_slot_dropped", 32'(saw_v), 32'h0);

    run_slot(sid(3, 5), 16'h1234, 1'b0, '0, '0, 1'b0, '0,
             g_ph, g_alg, g_id, g_note, lat);
    check("post_clear_phase", 32'(g_ph), 32'h1234);
    check("post_clear_alg", 32'(g_alg), 32'h0);
    check("post_clear_lat", 32'(lat), 32'(LAT));
    check("noteon_pass", 32'(g_note), 32'h1);

    for (int i = 0; i < 11; i++) begin
      algw(sid(3, 5), vt[i].alg);
      for (int k = 0; k < 6; k++) wb(sid(3, k), vt[i].w[k]);
      run_slot(sid(3, 5), vt[i].ph, 1'b0, '0, '0, 1'b0, '0,
               g_ph, g_alg, g_id, g_note, lat);
      check($sformatf("vec%0d_phase", i), 32'(g_ph), 32'(vt[i].exp));
      check($sformatf("vec%0d_alg", i), 32'(g_alg), 32'(vt[i].alg[9:0]));
      check($sformatf("vec%0d_id", i), 32'(g_id), 32'(sid(3, 5)));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(LAT));
    end

    // Writeback bypass into the stage-0 read.
    algw(sid(3, 5), 16'h001);
    wb(sid(3, 0), 16'h1000);
    run_slot(sid(3, 5), 16'h1234, 1'b1, sid(3, 0), 16'h0400, 1'b0, '0,
             g_ph, g_alg, g_id, g_note, lat);
    check("wb_bypass_phase", 32'(g_ph), 32'h1434);

    // Algorithm write bypass.
    wb(sid(3, 0), 16'h2000);
    algw(sid(3, 5), 16'h000);
    run_slot(sid(3, 5), 16'h1234, 1'b0, '0, '0, 1'b1, 16'h001,
             g_ph, g_alg, g_id, g_note, lat);
    check("alg_bypass_phase", 32'(g_ph), 32'h2234);
    check("alg_bypass_alg", 32'(g_alg), 32'h001);

    // Self-feedback, level 7.
    algw(sid(7, 2), 16'h380);
    wb(sid(7, 2), 16'h0100);
    wb(sid(7, 2), 16'h0100);
    run_slot(sid(7, 2), 16'h1234, 1'b0, '0, '0, 1'b0, '0,
             g_ph, g_alg, g_id, g_note, lat);
`ifdef OCTANE_MODULATOR_FEEDBACK_EN
    exp_fb = 16'h12B4;
`else
    exp_fb = 16'h1234;
`endif
    check("feedback_phase", 32'(g_ph), 32'(exp_fb));
    check("feedback_alg", 32'(g_alg), 32'h380);

    // Reset mid-flight.
    vin = 1'b1; vo = sid(3, 5); ph_in = 16'h7777;
    @(negedge clk);
    vin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(vout), 32'h0);
    check("midrst_ready", 32'(rdy), 32'h0);
    check("midrst_phase", 32'(ph_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(cyc, saw_v);
    check("midrst_clear_cycles", 32'(cyc), 32'(CLR));
    check("midrst_no_valid", 32'(saw_v), 32'h0);
    run_slot(sid(3, 5), 16'h5555, 1'b0, '0, '0, 1'b0, '0,
             g_ph, g_alg, g_id, g_note, lat);
    check("midrst_tables_phase", 32'(g_ph), 32'h5555);
    check("midrst_tables_alg", 32'(g_alg), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
